// File: rtl/car_game_pkg.sv
// Shared types and constants for the VGA car demo.
//   state_t : motion FSM states (IDLE, ACCEL, CRUISE, BRAKE)
//   cmd_t   : drive command decoded from the debounced buttons
//   Screen geometry (H_ACTIVE, V_ACTIVE, CAR_W) and datapath widths (X_W, SPD_W).
package car_game_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CAR_W    = 50;

    localparam int X_W   = 10;
    localparam int SPD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } cmd_t;

    // Both buttons held cancel each other out, exactly like no button.
    function automatic cmd_t decode_cmd(input logic left, input logic right);
        cmd_t c;
        case ({left, right})
            2'b10:   c = LEFT;
            2'b01:   c = RIGHT;
            default: c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a frame-sampled
// debounce counter.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   frame_start  : one-cycle pulse per frame; the only time the button is sampled
//   btn_raw      : asynchronous raw button
//   level        : debounced button level
module btn_debounce #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic btn_raw,
    output logic level
);

    localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_FRAMES - 1);

    logic [1:0] sync_q;
    logic [2:0] cnt;

    // cnt counts consecutive frame samples that disagree with the current
    // level; the level flips on the sample that completes the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (frame_start) begin
                if (sync_q[1] != level) begin
                    if (cnt == CNT_LAST) begin
                        level <= ~level;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/car_motion_ctrl.sv
// Frame-synchronous motion controller for the player car.
// Debounces the left/right buttons, runs an accelerate/cruise/brake FSM and
// advances the car position once per frame (on the frame_start edge, during
// vertical blanking) so the renderer never sees a mid-frame change.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   frame_start    : one-cycle pulse at start of vertical blanking
//   btn_left/right : raw asynchronous buttons
//   car_x          : car left edge in pixels, always within [0, X_MAX]
//   speed, dir     : pixels per frame, 1 = right / 0 = left
//   moving         : speed != 0
//   at_left_edge   : car_x == 0
//   at_right_edge  : car_x == X_MAX
module car_motion_ctrl
    import car_game_pkg::*;
#(
    parameter int X_MAX           = H_ACTIVE - CAR_W,
    parameter int X_RESET         = 0,
    parameter int MAX_SPEED       = 8,
    parameter int ACCEL_FRAMES    = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [X_W-1:0]   car_x,
    output logic [SPD_W-1:0] speed,
    output logic             dir,
    output logic             moving,
    output logic             at_left_edge,
    output logic             at_right_edge
);

    localparam logic [X_W:0]     X_MAX_EXT = (X_W + 1)'(X_MAX);
    localparam logic [X_W-1:0]   X_MAX_V   = X_W'(X_MAX);
    localparam logic [X_W-1:0]   X_RESET_V = X_W'(X_RESET);
    localparam logic [SPD_W-1:0] MAX_SPD_V = SPD_W'(MAX_SPEED);
    localparam logic [SPD_W-1:0] SPD_ONE   = SPD_W'(1);
    localparam logic [3:0]       ACC_LAST  = 4'(ACCEL_FRAMES - 1);

    logic             lvl_left;
    logic             lvl_right;
    cmd_t             cmd;
    logic             cmd_match;
    state_t           state;
    logic [3:0]       acc_cnt;
    logic [SPD_W-1:0] spd_inc;
    logic [X_W-1:0]   spd_x;
    logic [X_W:0]     x_plus;
    logic             hit_right;
    logic             hit_left;
    logic             wall_hit;
    logic [X_W-1:0]   x_next;

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_left (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_raw     (btn_left),
        .level       (lvl_left)
    );

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_right (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_raw     (btn_right),
        .level       (lvl_right)
    );

    // Command comes from the levels registered at the previous frame.
    assign cmd       = decode_cmd(lvl_left, lvl_right);
    assign cmd_match = ((cmd == RIGHT) && dir) || ((cmd == LEFT) && !dir);
    assign spd_inc   = speed + SPD_ONE;

    // Position update uses the speed held before this edge. The sum is one
    // bit wider so the right-wall test cannot wrap.
    assign spd_x     = {{(X_W - SPD_W){1'b0}}, speed};
    assign x_plus    = {1'b0, car_x} + {1'b0, spd_x};
    assign hit_right = dir  && moving && (x_plus >= X_MAX_EXT);
    assign hit_left  = !dir && moving && (car_x <= spd_x);
    assign wall_hit  = hit_right || hit_left;

    always_comb begin
        x_next = car_x;
        if (hit_right) begin
            x_next = X_MAX_V;
        end else if (hit_left) begin
            x_next = '0;
        end else if (moving) begin
            x_next = dir ? x_plus[X_W-1:0] : (car_x - spd_x);
        end
    end

    // Everything advances only on the edge that samples frame_start; a wall
    // hit takes priority over whatever the FSM would do on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            speed   <= '0;
            dir     <= 1'b1;
            acc_cnt <= '0;
            car_x   <= X_RESET_V;
        end else if (frame_start) begin
            car_x <= x_next;
            if (wall_hit) begin
                state   <= IDLE;
                speed   <= '0;
                acc_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd != NONE) begin
                            dir     <= (cmd == RIGHT);
                            speed   <= SPD_ONE;
                            acc_cnt <= '0;
                            state   <= (MAX_SPD_V == SPD_ONE) ? CRUISE : ACCEL;
                        end
                    end
                    ACCEL: begin
                        if (!cmd_match) begin
                            state <= BRAKE;
                        end else if (acc_cnt == ACC_LAST) begin
                            acc_cnt <= '0;
                            speed   <= spd_inc;
                            if (spd_inc == MAX_SPD_V) begin
                                state <= CRUISE;
                            end
                        end else begin
                            acc_cnt <= acc_cnt + 4'd1;
                        end
                    end
                    CRUISE: begin
                        if (!cmd_match) begin
                            state <= BRAKE;
                        end
                    end
                    BRAKE: begin
                        // Re-pressing the current direction resumes
                        // acceleration from the speed already reached.
                        if (cmd_match) begin
                            state   <= ACCEL;
                            acc_cnt <= '0;
                        end else if (speed <= SPD_ONE) begin
                            speed <= '0;
                            state <= IDLE;
                        end else begin
                            speed <= speed - SPD_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign moving        = (speed != '0);
    assign at_left_edge  = (car_x == '0);
    assign at_right_edge = (car_x == X_MAX_V);

endmodule

// File: tb/tb_car_motion_ctrl.sv
module tb_car_motion_ctrl;

    localparam int XMAX = 590;
    localparam int MAXS = 8;
    localparam int AF   = 4;
    localparam int DB   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start;
    logic btn_left;
    logic btn_right;

    logic [9:0] car_x0, car_x1;
    logic [3:0] speed0, speed1;
    logic       dir0, dir1, moving0, moving1;
    logic       le0, le1, re0, re1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int x; int spd; int dir; int st; int acc;
        int lvl_l; int lvl_r; int cnt_l; int cnt_r;
    } mdl_t;

    typedef struct {
        int inst; int x; int spd; int dir;
    } exp_t;

    mdl_t m[2];
    exp_t sb[$];

    car_motion_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .btn_left(btn_left), .btn_right(btn_right),
        .car_x(car_x0), .speed(speed0), .dir(dir0), .moving(moving0),
        .at_left_edge(le0), .at_right_edge(re0)
    );

    car_motion_ctrl #(.X_RESET(580)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .btn_left(btn_left), .btn_right(btn_right),
        .car_x(car_x1), .speed(speed1), .dir(dir1), .moving(moving1),
        .at_left_edge(le1), .at_right_edge(re1)
    );

    always #5 clk = ~clk;

    function automatic mdl_t mdl_init(input int xr);
        mdl_t s;
        s.x = xr; s.spd = 0; s.dir = 1; s.st = 0; s.acc = 0;
        s.lvl_l = 0; s.lvl_r = 0; s.cnt_l = 0; s.cnt_r = 0;
        return s;
    endfunction

    // Frame-level behavioural model of the controller.
    function automatic mdl_t mdl_step(input mdl_t s, input int bl, input int br);
        mdl_t n = s;
        int cmd;
        bit fwd;
        bit hit = 1'b0;
        cmd = (s.lvl_l == 1 && s.lvl_r == 0) ? 1 : (s.lvl_r == 1 && s.lvl_l == 0) ? 2 : 0;
        if (bl != s.lvl_l) begin
            n.cnt_l = s.cnt_l + 1;
            if (n.cnt_l == DB) begin n.lvl_l = 1 - s.lvl_l; n.cnt_l = 0; end
        end else n.cnt_l = 0;
        if (br != s.lvl_r) begin
            n.cnt_r = s.cnt_r + 1;
            if (n.cnt_r == DB) begin n.lvl_r = 1 - s.lvl_r; n.cnt_r = 0; end
        end else n.cnt_r = 0;
        fwd = (cmd == 2 && s.dir == 1) || (cmd == 1 && s.dir == 0);
        if (s.spd != 0) begin
            if (s.dir == 1) begin
                if (s.x + s.spd >= XMAX) begin n.x = XMAX; hit = 1'b1; end
                else n.x = s.x + s.spd;
            end else begin
                if (s.x <= s.spd) begin n.x = 0; hit = 1'b1; end
                else n.x = s.x - s.spd;
            end
        end
        case (s.st)
            0: if (cmd != 0) begin
                   n.dir = (cmd == 2) ? 1 : 0; n.spd = 1; n.acc = 0;
                   n.st = (MAXS == 1) ? 2 : 1;
               end
            1: if (!fwd) n.st = 3;
               else if (s.acc == AF - 1) begin
                   n.acc = 0; n.spd = s.spd + 1;
                   if (n.spd == MAXS) n.st = 2;
               end else n.acc = s.acc + 1;
            2: if (!fwd) n.st = 3;
            default: if (fwd) begin n.st = 1; n.acc = 0; end
                     else begin n.spd = s.spd - 1; if (n.spd == 0) n.st = 0; end
        endcase
        if (hit) begin n.spd = 0; n.st = 0; n.acc = 0; end
        return n;
    endfunction

    task automatic reset_models();
        m[0] = mdl_init(0);
        m[1] = mdl_init(580);
    endtask

    // One frame: model predictions are queued as the pulse is driven and
    // compared against both DUTs on the following falling edge.
    task automatic do_frame();
        exp_t e;
        logic [9:0] ox; logic [3:0] os; logic od; logic [2:0] of;
        logic [2:0] ef;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m[i] = mdl_step(m[i], int'(btn_left), int'(btn_right));
            sb.push_back('{i, m[i].x, m[i].spd, m[i].dir});
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin ox = car_x0; os = speed0; od = dir0; of = {moving0, le0, re0}; end
            else             begin ox = car_x1; os = speed1; od = dir1; of = {moving1, le1, re1}; end
            ef = {e.spd != 0, e.x == 0, e.x == XMAX};
            n_checks++;
            if ({22'b0, ox} !== e.x) $display("FAIL sb_car_x[%0d] got %0d want %0d", e.inst, ox, e.x);
            else n_pass++;
            n_checks++;
            if ({28'b0, os} !== e.spd) $display("FAIL sb_speed[%0d] got %0d want %0d", e.inst, os, e.spd);
            else n_pass++;
            n_checks++;
            if ({31'b0, od} !== e.dir) $display("FAIL sb_dir[%0d] got %0d want %0d", e.inst, od, e.dir);
            else n_pass++;
            n_checks++;
            if (of !== ef) $display("FAIL sb_flags[%0d] got %b want %b", e.inst, of, ef);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; btn_left = 1'b0; btn_right = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_checks++;
        if (car_x0 !== 10'd0 || speed0 !== 4'd0 || dir0 !== 1'b1)
            $display("FAIL reset0 got x=%0d s=%0d d=%0d want x=0 s=0 d=1", car_x0, speed0, dir0);
        else n_pass++;
        n_checks++;
        if (car_x1 !== 10'd580 || speed1 !== 4'd0)
            $display("FAIL reset1 got x=%0d s=%0d want x=580 s=0", car_x1, speed1);
        else n_pass++;
        n_checks++;
        if ({moving0, le0, re0} !== 3'b010)
            $display("FAIL reset_flags got %b want 010", {moving0, le0, re0});
        else n_pass++;
        btn_right = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        reset_models();
    endtask

    task automatic test_right_accel();
        int ex1[7] = '{581, 582, 583, 584, 586, 588, 590};
        btn_right = 1'b1;
        for (int f = 1; f <= 32; f++) begin
            do_frame();
            if (f == 2) begin
                n_checks++;
                if (speed0 !== 4'd0) $display("FAIL accel_latency got speed=%0d want 0", speed0);
                else n_pass++;
            end
            if (f == 3) begin
                n_checks++;
                if (speed0 !== 4'd1) $display("FAIL accel_start got speed=%0d want 1", speed0);
                else n_pass++;
            end
            if (f == 7) begin
                n_checks++;
                if (speed0 !== 4'd2) $display("FAIL accel_step got speed=%0d want 2", speed0);
                else n_pass++;
            end
            if (f >= 4 && f <= 10) begin
                n_checks++;
                if ({22'b0, car_x1} !== ex1[f-4])
                    $display("FAIL edge_x f%0d got %0d want %0d", f, car_x1, ex1[f-4]);
                else n_pass++;
            end
            if (f == 10) begin
                n_checks++;
                if (speed1 !== 4'd0 || re1 !== 1'b1)
                    $display("FAIL wall_hit got speed=%0d re=%0d want 0 1", speed1, re1);
                else n_pass++;
            end
            if (f == 31) begin
                n_checks++;
                if (speed0 !== 4'd8 || car_x0 !== 10'd112)
                    $display("FAIL cruise got speed=%0d x=%0d want 8 112", speed0, car_x0);
                else n_pass++;
            end
        end
        n_checks++;
        if (car_x0 !== 10'd120 || car_x1 !== 10'd590)
            $display("FAIL cruise_x got x0=%0d x1=%0d want 120 590", car_x0, car_x1);
        else n_pass++;
    endtask

    task automatic brake_sequence(input string tag);
        int exs[11] = '{8, 8, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        for (int f = 0; f < 11; f++) begin
            do_frame();
            n_checks++;
            if ({28'b0, speed0} !== exs[f])
                $display("FAIL %s_speed r%0d got %0d want %0d", tag, f + 1, speed0, exs[f]);
            else n_pass++;
        end
        n_checks++;
        if (dir0 !== 1'b1 || moving0 !== 1'b0)
            $display("FAIL %s_end got dir=%0d moving=%0d want 1 0", tag, dir0, moving0);
        else n_pass++;
    endtask

    task automatic test_release_brake();
        btn_right = 1'b0;
        brake_sequence("release");
    endtask

    task automatic test_both_buttons();
        btn_right = 1'b1;
        for (int f = 0; f < 31; f++) do_frame();
        n_checks++;
        if (speed0 !== 4'd8) $display("FAIL both_precruise got speed=%0d want 8", speed0);
        else n_pass++;
        btn_left = 1'b1;
        brake_sequence("both");
        btn_left = 1'b0;
        btn_right = 1'b0;
        for (int f = 0; f < 3; f++) do_frame();
    endtask

    task automatic test_glitch();
        int x_hold = m[0].x;
        btn_right = 1'b1;
        do_frame();
        btn_right = 1'b0;
        for (int f = 0; f < 4; f++) begin
            do_frame();
            n_checks++;
            if (speed0 !== 4'd0 || {22'b0, car_x0} !== x_hold)
                $display("FAIL glitch f%0d got speed=%0d x=%0d want 0 %0d", f, speed0, car_x0, x_hold);
            else n_pass++;
        end
    endtask

    task automatic test_left_edge();
        bit reached = 1'b0;
        btn_left = 1'b1;
        for (int f = 0; f < 120 && !reached; f++) begin
            do_frame();
            if (m[0].x == 0 && m[0].spd == 0) reached = 1'b1;
        end
        n_checks++;
        if (!reached) $display("FAIL left_edge_timeout got no arrival want arrival within 120 frames");
        else n_pass++;
        n_checks++;
        if (car_x0 !== 10'd0 || le0 !== 1'b1 || speed0 !== 4'd0 || dir0 !== 1'b0)
            $display("FAIL left_edge got x=%0d le=%0d s=%0d d=%0d want 0 1 0 0", car_x0, le0, speed0, dir0);
        else n_pass++;
        btn_left = 1'b0;
        for (int f = 0; f < 4; f++) do_frame();
    endtask

    task automatic test_reset_mid_cruise();
        btn_right = 1'b1;
        for (int f = 0; f < 31; f++) do_frame();
        n_checks++;
        if (speed0 !== 4'd8) $display("FAIL mid_precruise got speed=%0d want 8", speed0);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        n_checks++;
        if (car_x0 !== 10'd0 || speed0 !== 4'd0 || dir0 !== 1'b1 || car_x1 !== 10'd580)
            $display("FAIL mid_reset got x0=%0d s=%0d d=%0d x1=%0d want 0 0 1 580",
                     car_x0, speed0, dir0, car_x1);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        reset_models();
        for (int f = 1; f <= 3; f++) begin
            do_frame();
            n_checks++;
            if ({28'b0, speed0} !== ((f == 3) ? 1 : 0) || car_x0 !== 10'd0)
                $display("FAIL post_reset f%0d got s=%0d x=%0d want s=%0d x=0",
                         f, speed0, car_x0, (f == 3) ? 1 : 0);
            else n_pass++;
        end
    endtask

    initial begin
        reset_models();
        test_reset();
        test_right_accel();
        test_release_brake();
        test_both_buttons();
        test_glitch();
        test_left_edge();
        test_reset_mid_cruise();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
